// File: rtl/modq_pkg.sv
// -----------------------------------------------------------------------------
// modq_pkg
// Shared definitions for blocks working in GF(2^255 - 19).
//   W        operand / result width
//   Q        field modulus 2^255 - 19
//   MAX_IDXW widest requester index carried through the tag pipe (NREQ <= 8)
//   tag_t    tag pipe entry: valid flag plus requester index
//   idx_w()  index width for a given requester count (at least one bit)
// -----------------------------------------------------------------------------
package modq_pkg;

  localparam int W = 255;

  // 2^255 - 19: all ones except the low byte, which is -19 = 8'hED
  localparam logic [W-1:0] Q = {{(W-8){1'b1}}, 8'hED};

  localparam int MAX_IDXW = 3;

  typedef struct packed {
    logic                vld;
    logic [MAX_IDXW-1:0] idx;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modmul_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Scans the request vector starting at the
// pointer (wrapping) and grants the first set bit.
// Ports:
//   req       in  NREQ  eligible requesters
//   ptr       in  IDXW  highest-priority index this cycle
//   grant     out NREQ  one-hot grant (all zero when no request)
//   grant_idx out IDXW  binary index of the granted requester
//   any       out 1     some requester was granted
//   next_ptr  out IDXW  pointer value to load if the grant is taken
// -----------------------------------------------------------------------------
module rr_arbiter
  import modq_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any,
  output logic [IDXW-1:0] next_ptr
);

  logic [IDXW-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = IDXW'((int'(ptr) + k) % NREQ);
      if (!any && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        any        = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next time.
  always_comb begin
    if (int'(grant_idx) == NREQ - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/modmul_arbiter.sv
// -----------------------------------------------------------------------------
// modmul_arbiter
// Shares one fixed-latency GF(2^255-19) multiplier among NREQ requesters.
// Round-robin grant, one issue per cycle, a tag pipe that tracks which
// requester owns each result, and per-requester in-flight limits.
// Latency from acceptance to response is LAT+2 cycles regardless of load.
// Ports:
//   clk          in  1       rising-edge clock
//   rst          in  1       synchronous, active-low reset
//   req_valid    in  NREQ    requester i has an operand pair
//   req_ready    out NREQ    one-hot grant (combinational)
//   req_a, req_b in  NREQ*W  flattened operands, slice i = [i*W +: W]
//   mul_in_valid out 1       issue strobe to the multiplier
//   mul_a, mul_b out W       operands to the multiplier
//   mul_res      in  W       reduced product, LAT cycles after issue
//   rsp_valid    out NREQ    one-hot response strobe
//   rsp_data     out W       response data
//   idle         out 1       nothing in flight, no response pending
// -----------------------------------------------------------------------------
module modmul_arbiter
  import modq_pkg::tag_t, modq_pkg::Q, modq_pkg::MAX_IDXW, modq_pkg::idx_w;
#(
  parameter int NREQ    = 4,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2,
  parameter int W       = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              mul_in_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [W-1:0]      mul_res,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              idle
);

  localparam int IDXW = idx_w(NREQ);
  localparam int CNTW = $clog2(MAX_OUT + 1);

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] next_ptr;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant;
  logic            any;
  logic            accept;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [CNTW-1:0] cnt [NREQ];
  logic [IDXW-1:0] iss_idx_p0;
  tag_t            tag_p1 [LAT];
  tag_t            tag_out;
  logic [NREQ-1:0] rsp_nxt;

  // A requester whose response is on rsp_valid this cycle counts as already
  // decremented, so it is eligible again in that same cycle.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand[i] = req_valid[i] && ((int'(cnt[i]) < MAX_OUT) || rsp_valid[i]);
    end
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req      (cand),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(grant_idx),
    .any      (any),
    .next_ptr (next_ptr)
  );

  assign req_ready = rst ? grant : '0;
  assign accept    = rst && any;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // ---- stage p0: issue register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr       <= '0;
      mul_in_valid <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      iss_idx_p0   <= '0;
    end else begin
      mul_in_valid <= accept;
      if (accept) begin
        rr_ptr     <= next_ptr;
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        iss_idx_p0 <= grant_idx;
      end
    end
  end

  // ---- stage p1: tag pipe, output lines up with mul_res ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        tag_p1[k] <= '0;
      end
    end else begin
      tag_p1[0] <= '{vld: mul_in_valid, idx: MAX_IDXW'(iss_idx_p0)};
      for (int k = 1; k < LAT; k++) begin
        tag_p1[k] <= tag_p1[k-1];
      end
    end
  end

  assign tag_out = tag_p1[LAT-1];

  always_comb begin
    rsp_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_nxt[i] = tag_out.vld && (tag_out.idx == MAX_IDXW'(i));
    end
  end

  // ---- stage p2: response register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_nxt;
      if (tag_out.vld) begin
        rsp_data <= mul_res;
      end
    end
  end

  // In-flight counters: span acceptance through the response cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({accept && grant[i], rsp_valid[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt[i] != '0) begin
        idle = 1'b0;
      end
    end
  end

  // Operands must already be reduced; anything else is a caller bug.
  a_operand_lt_q : assert property (@(posedge clk) disable iff (!rst)
    accept |-> ((sel_a < W'(Q)) && (sel_b < W'(Q))));

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant));

  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(rsp_valid));

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_chk
    a_cnt_limit : assert property (@(posedge clk) disable iff (!rst)
      int'(cnt[g]) <= MAX_OUT);
  end

endmodule

// File: doc/modmul_arbiter.md
# modmul_arbiter

Shares one fixed-latency GF(2^255−19) multiplier pipeline among several requesters. The pipeline is the Karatsuba partial-product stage followed by the ModQ reduction stage. The block grants requesters round-robin, issues one operand pair per cycle, and tags each operation through the pipeline. It routes each reduced result back to the requester that issued it. It sits between the point-add/double sequencers and the shared multiplier in the scalar-multiplication core.

## Interface
- NREQ, 4: number of requesters (2..8)
- LAT, 3: multiplier latency, cycles from mul_in_valid to mul_res valid (≥1)
- MAX_OUT, 2: max in-flight operations per requester (1..LAT+1)
- W, 255: operand/result width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot grant, combinational
- req_a, req_b  in  NREQ*W  flattened operands, slice i = [i*W +: W], each < q
- mul_in_valid  out  1  registered issue strobe to multiplier
- mul_a, mul_b  out  W  registered operands
- mul_res  in  W  reduced product, valid exactly LAT cycles after the matching issue
- rsp_valid  out  NREQ  registered one-hot response strobe
- rsp_data  out  W  registered result, valid with rsp_valid
- idle  out  1  no operation in flight and no response pending

## Operation
- Arbitration: the candidate set is i where req_valid[i] && cnt[i] < MAX_OUT.
  - The first candidate at or after rr_ptr (wrapping) receives req_ready[i] = 1.
  - Acceptance is req_valid[i] && req_ready[i]. At most one acceptance per cycle.
- rr_ptr, reset 0: on acceptance it becomes (granted index + 1) mod NREQ. With no acceptance it holds.
- Issue register: captures the accepted operands. mul_in_valid = 1 the next cycle, otherwise 0. mul_a/mul_b hold their last value when not valid.
- Tag pipe: LAT-deep shift register of {valid, index[$clog2(NREQ)-1:0]}, loaded from the issue register.
  - Its output aligns with mul_res.
  - When the output is valid, rsp_valid[index] <= 1 and rsp_data <= mul_res next cycle.
- There is no response backpressure: a requester must accept rsp_valid in the cycle it is asserted.
- cnt[i] (0..MAX_OUT) increments on acceptance of i and decrements when rsp_valid[i] is asserted.
  - If both happen in the same cycle, cnt[i] is unchanged.
- idle = all cnt == 0.
- An operand ≥ q is a protocol violation. Behaviour is undefined and flagged only by an SVA assertion.

## Timing
- Acceptance in cycle t → mul_in_valid at t+1 → mul_res at t+1+LAT → rsp_valid at t+2+LAT.
- Fixed latency LAT+2 regardless of contention.
- Throughput: one issue per cycle sustained while candidates exist.
- Responses return in issue order. Different requesters interleave freely.
- A requester at cnt == MAX_OUT loses ready and is skipped. It is re-eligible in the cycle its rsp_valid is asserted, since the counter is seen as decrementing.
- Reset (rst = 0 in any cycle), applied next edge:
  - rr_ptr = 0, all cnt = 0, tag pipe cleared.
  - mul_in_valid = 0, rsp_valid = 0, rsp_data = 0, mul_a = mul_b = 0.
  - idle = 1.
  - req_ready = 0 while rst = 0.
- In-flight operations at reset are discarded. Stale mul_res values are ignored because the tag pipe is empty.
- NREQ = 1 degenerates to pass-through with the limit and tagging still applied.

## Structure
- Shared package modq_pkg:
  - constant Q = 2^255 − 19
  - W
  - tag typedef {logic vld; logic [IDXW-1:0] idx}
  - function idx_w(NREQ)
- Sub-module rr_arbiter (NREQ): combinational request/pointer → one-hot grant, plus pointer-update logic.
- Top level holds the issue register, tag pipe, counters and response register.
- The multiplier itself stays outside this block.

## Test plan
- Single request: NREQ = 4, LAT = 3, requester 2 issues a = 3, b = 5 at t0.
  - mul_in_valid at t0+1 with mul_a = 3, mul_b = 5.
  - Model returns 15 at t0+4.
  - rsp_valid = 4'b0100, rsp_data = 15 at t0+5.
  - idle returns to 1.
- All four requesters valid continuously, rr_ptr = 0: grants cycle 0,1,2,3,0,…, with one mul_in_valid per cycle.
- Wrap-around: a = q − 1, b = q − 1 gives rsp_data = 1; a = 2^254, b = 2 gives rsp_data = 19.
- MAX_OUT = 2, only requester 1 valid for 6 cycles.
  - Accepted at t0 and t0+1, then ready low.
  - Re-accepted at t0+5, the cycle of its first rsp_valid.
  - cnt never exceeds 2.
- Reset asserted 2 cycles after three acceptances.
  - No rsp_valid afterward, even though the model still drives mul_res.
  - idle = 1, rr_ptr = 0; the next grant goes to the lowest valid index.
